// File: rtl/coin_pulse_gen_if.sv
// Coin front-end bus: raw sensor lines in, conditioned coin pulses out.
interface coin_pulse_gen_if;
  logic raw_coin_one;
  logic raw_coin_half;
  logic po_money_one;
  logic po_money_half;
  logic po_coin_lost;

  modport master (
    output raw_coin_one, raw_coin_half,
    input  po_money_one, po_money_half, po_coin_lost
  );
  modport slave (
    input  raw_coin_one, raw_coin_half,
    output po_money_one, po_money_half, po_coin_lost
  );
endinterface

// File: rtl/coin_pulse_gen.sv
// Coin sensor conditioner: sync + debounce per channel, then a one-pulse-per-coin
// arbiter that never presents two coins in the same cycle (1-yuan wins, 0.5 waits one cycle).

module coin_deb #(
  parameter int DEBOUNCE_CNT = 999_999,
  parameter int CNT_W        = $clog2(DEBOUNCE_CNT)
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_raw,
  output logic o_rise
);
  logic             r_s1, r_s2, r_deb, r_deb_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      // any return to the accepted level restarts the stability window
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_deb & ~r_deb_d;
endmodule

module coin_pulse_gen #(
  parameter int DEBOUNCE_CNT = 999_999,
  parameter int CNT_W        = $clog2(DEBOUNCE_CNT)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  coin_pulse_gen_if.slave  bus
);
  localparam int NUM_LANES = 2;  // lane 0 = 1 yuan, lane 1 = 0.5 yuan

  logic [NUM_LANES-1:0] w_raw, w_rise;
  logic                 w_cand_one, w_cand_half;
  logic                 r_pend_half, r_po_one, r_po_half, r_lost;

  assign w_raw = {bus.raw_coin_half, bus.raw_coin_one};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    coin_deb #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .CNT_W(CNT_W)) u_deb (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .i_raw     (w_raw[g]),
      .o_rise    (w_rise[g])
    );
  end

  assign w_cand_one  = w_rise[0];
  assign w_cand_half = r_pend_half | w_rise[1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pend_half <= 1'b0;
      r_po_one    <= 1'b0;
      r_po_half   <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      // a half coin arriving while one is already parked behind a 1-yuan pulse is dropped
      r_lost <= w_rise[1] & r_pend_half & w_cand_one;
      if (w_cand_one) begin
        r_po_one    <= 1'b1;
        r_po_half   <= 1'b0;
        r_pend_half <= w_cand_half;
      end else if (w_cand_half) begin
        r_po_one    <= 1'b0;
        r_po_half   <= 1'b1;
        r_pend_half <= 1'b0;
      end else begin
        r_po_one    <= 1'b0;
        r_po_half   <= 1'b0;
      end
    end
  end

  assign bus.po_money_one  = r_po_one;
  assign bus.po_money_half = r_po_half;
  assign bus.po_coin_lost  = r_lost;
endmodule

// File: tb/tb_coin_pulse_gen.sv
// Directed bench for coin_pulse_gen with a 4-cycle debounce window.
module tb_coin_pulse_gen;
  logic sys_clk = 1'b0;
  logic sys_rst_n;

  coin_pulse_gen_if u_if ();

  coin_pulse_gen #(.DEBOUNCE_CNT(4)) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (u_if)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tot = 0;
  int n_bad = 0;
  int idx, n_one, n_half, n_lost, n_both, first_one, last_one, first_half;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    idx = 0; n_one = 0; n_half = 0; n_lost = 0; n_both = 0;
    first_one = -1; last_one = -1; first_half = -1;
  endtask

  // advance n edges, logging output activity by edge index within the test
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge sys_clk);
      idx++;
      #1;
      if (u_if.po_money_one === 1'b1) begin
        n_one++;
        if (first_one < 0) first_one = idx;
        last_one = idx;
      end
      if (u_if.po_money_half === 1'b1) begin
        n_half++;
        if (first_half < 0) first_half = idx;
      end
      if (u_if.po_coin_lost === 1'b1) n_lost++;
      if (u_if.po_money_one === 1'b1 && u_if.po_money_half === 1'b1) n_both++;
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    u_if.raw_coin_one  = 1'b0;
    u_if.raw_coin_half = 1'b0;
    #12;
    chk("rst_one",  int'(u_if.po_money_one),  0);
    chk("rst_half", int'(u_if.po_money_half), 0);
    chk("rst_lost", int'(u_if.po_coin_lost),  0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    step(5);

    // 1: single 1-yuan coin
    clr();
    u_if.raw_coin_one = 1'b1; step(20);
    u_if.raw_coin_one = 1'b0; step(15);
    chk("t1_first_one", first_one, 7);
    chk("t1_n_one",     n_one,     1);
    chk("t1_n_half",    n_half,    0);
    chk("t1_n_lost",    n_lost,    0);

    // 2: bouncing half coin, then a clean hold starting at edge 11
    clr();
    for (int i = 1; i <= 10; i++) begin
      u_if.raw_coin_half = (i % 2 == 1);
      step(1);
    end
    u_if.raw_coin_half = 1'b1; step(10);
    u_if.raw_coin_half = 1'b0; step(15);
    chk("t2_first_half", first_half, 17);
    chk("t2_n_half",     n_half,     1);
    chk("t2_n_one",      n_one,      0);

    // 3: simultaneous coins -> one first, half exactly one cycle later
    clr();
    u_if.raw_coin_one = 1'b1; u_if.raw_coin_half = 1'b1; step(20);
    u_if.raw_coin_one = 1'b0; u_if.raw_coin_half = 1'b0; step(15);
    chk("t3_first_one",  first_one,  7);
    chk("t3_first_half", first_half, 8);
    chk("t3_n_one",      n_one,      1);
    chk("t3_n_half",     n_half,     1);
    chk("t3_both",       n_both,     0);
    chk("t3_lost",       n_lost,     0);

    // 4: glitch shorter than the debounce window
    clr();
    u_if.raw_coin_one = 1'b1; step(3);
    u_if.raw_coin_one = 1'b0; step(20);
    chk("t4_n_one", n_one, 0);

    // 5: two coins, 10 high / 10 low / 10 high
    clr();
    u_if.raw_coin_one = 1'b1; step(10);
    u_if.raw_coin_one = 1'b0; step(10);
    u_if.raw_coin_one = 1'b1; step(10);
    u_if.raw_coin_one = 1'b0; step(15);
    chk("t5_first_one", first_one, 7);
    chk("t5_last_one",  last_one,  27);
    chk("t5_n_one",     n_one,     2);

    // 6: reset mid-count, raw still high at release
    clr();
    u_if.raw_coin_one = 1'b1; step(5);
    sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_one",  int'(u_if.po_money_one),  0);
    chk("t6_rst_half", int'(u_if.po_money_half), 0);
    clr();
    step(3);
    chk("t6_rst_n_one", n_one, 0);
    sys_rst_n = 1'b1;
    clr();
    step(12);
    chk("t6_first_one", first_one, 7);
    chk("t6_n_one",     n_one,     1);
    u_if.raw_coin_one = 1'b0; step(15);
    chk("t6_n_half",    n_half,    0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
